branch_cmp_serial: RTL and testbench
====================================

Name: branch_cmp_serial

Overview:
- Parametrised, multi-mode successor to the single-cycle ID-stage equality comparator.
- Compares two WIDTH-bit register operands DIGIT bits per cycle, MSB first.
- Supports EQ/NE/LT/GE in signed and unsigned forms.
- Start/ready/valid handshake and flush support let the ID stage use narrow compare logic at wide data widths and abort on pipeline redirect.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of DIGIT.
DIGIT, 8, bits compared per cycle (1..WIDTH); N = WIDTH/DIGIT cycles for a full compare.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a compare; accepted only when ready=1.
mode  input  3  0=EQ, 1=NE, 2=LT, 3=GE, 4=LTU, 5=GEU, 6/7 reserved (treated as EQ).
ID_rd1  input  WIDTH  operand A, sampled on the accepting edge.
ID_rd2  input  WIDTH  operand B, sampled on the accepting edge.
flush  input  1  abort the operation in flight.
ready  output  1  high only in IDLE.
valid  output  1  one-cycle pulse; result, zero and lt are valid while it is high.
result  output  1  mode-selected branch decision.
zero  output  1  A == B.
lt  output  1  A < B under the captured mode's signedness.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, ready=1, valid=0, result=0, zero=0, lt=0; operand, mode and counter registers cleared. Applies immediately, including mid-operation; no valid is produced for the aborted op.
- FSM states: IDLE, BUSY, DONE.
- IDLE: ready=1. On start=1 at a clock edge:
  - latch A, B and mode;
  - for signed modes (LT, GE), invert bit WIDTH-1 of both latched operands; this maps two's-complement ordering onto an unsigned compare;
  - digit counter=0; go to BUSY.
- BUSY: ready=0. Each edge compares the top DIGIT bits of A and B.
  - Equal digits: shift both operands left by DIGIT and increment the counter.
  - First differing digit: record decided=1 and lt_int = (digitA < digitB). Later digits do not change these values.
  - Leave BUSY when counter == N-1 (or earlier, see Optional Feature). On that edge, register into the outputs:
    - zero = !decided;
    - lt = decided & lt_int;
    - result: EQ=zero, NE=!zero, LT/LTU=lt, GE/GEU=!lt.
  - Go to DONE.
- DONE: valid=1 for exactly one cycle; ready=0; next edge returns to IDLE. start is ignored in DONE.
- result, zero and lt hold their last values until the next op completes or reset. valid alone qualifies them.
- Latency, full compare: start accepted at edge E0 → valid high in the cycle after edge EN. ready returns after edge EN+1.
- Back-to-back throughput: one op per N+2 cycles.
- flush=1 at any edge in BUSY or DONE: go to IDLE, valid=0 on the following cycle, outputs not updated.
  - flush in IDLE is a no-op.
  - flush together with start in IDLE: flush wins, start is not accepted.
- start while ready=0: ignored, with no side effects.
- DIGIT=WIDTH: N=1, single BUSY cycle.
- Reserved mode values behave exactly as EQ.

Optional Feature:
Macro: BRANCH_CMP_EARLY_EXIT_EN
- Defined: BUSY goes to DONE on the first edge that finds a differing digit, or at counter == N-1 if no difference is found.
  - Latency = k+1 edges, where k is the 0-based index of the first differing digit from the MSB.
  - Equal operands always take N edges.
- Not defined: every op takes exactly N BUSY edges, so latency is fixed.
- result, zero and lt values are identical in both builds.

Test Plan (WIDTH=32, DIGIT=8, N=4):
1. EQ, A=0, B=0 → valid after 4 BUSY edges; result=1, zero=1, lt=0; ready back 1 cycle after valid.
2. LTU, A=1, B=0 → result=0, zero=0, lt=0. Latency is 4 in both builds (difference is in the last digit).
3. LT, A=32'hFFFF_FFFF (-1), B=2 → result=1, lt=1. Latency: 1 BUSY edge with BRANCH_CMP_EARLY_EXIT_EN, 4 without. Repeat with LTU → result=0.
4. GE, A=4, B=4 → result=1, zero=1. Then NE, A=4, B=4 → result=0. Back-to-back ops at N+2-cycle spacing.
5. Flush: start EQ, A=5, B=5; flush=1 on the 2nd BUSY edge → no valid pulse, ready=1 next cycle, outputs unchanged. A following GEU, A=0, B=7 → result=0.
6. Async reset: deassert rst_n mid-BUSY between clock edges → ready=1, valid=result=zero=lt=0 immediately. After release, EQ, A=9, B=9 → result=1.

Source files
------------

// File: rtl/branch_cmp_serial_if.sv
// rtl/branch_cmp_serial_if.sv - handshake/operand bundle for branch_cmp_serial
//
// Purpose: groups the compare request, operands, flush and result signals.
// Signals:
//   start, mode[2:0], ID_rd1/ID_rd2[WIDTH-1:0], flush : requester -> comparator
//   ready, valid, result, zero, lt                   : comparator -> requester
// Modports: master (requester side), slave (comparator side).
interface branch_cmp_serial_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       mode;
   logic [WIDTH-1:0] ID_rd1;
   logic [WIDTH-1:0] ID_rd2;
   logic             flush;
   logic             ready;
   logic             valid;
   logic             result;
   logic             zero;
   logic             lt;

   modport master (
      output start, mode, ID_rd1, ID_rd2, flush,
      input  ready, valid, result, zero, lt
   );

   modport slave (
      input  start, mode, ID_rd1, ID_rd2, flush,
      output ready, valid, result, zero, lt
   );
endinterface

// File: rtl/branch_cmp_serial.sv
// rtl/branch_cmp_serial.sv - digit-serial EQ/NE/LT/GE(U) branch comparator
//
// Purpose: compares two WIDTH-bit operands DIGIT bits per cycle, MSB first,
// and reports a mode-selected branch decision plus zero/lt flags.
// Ports:
//   clk_i    : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   bus_if   : branch_cmp_serial_if.slave (start/mode/operands/flush in,
//              ready/valid/result/zero/lt out)
// Optional feature macro: BRANCH_CMP_EARLY_EXIT_EN
//   defined     - leave BUSY on the first differing digit
//   not defined - every compare takes exactly N BUSY cycles
module branch_cmp_serial #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input  logic                clk_i,
   input  logic                rst_n,
   branch_cmp_serial_if.slave  bus_if
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [2:0] M_EQ  = 3'd0;
   localparam logic [2:0] M_NE  = 3'd1;
   localparam logic [2:0] M_LT  = 3'd2;
   localparam logic [2:0] M_GE  = 3'd3;
   localparam logic [2:0] M_LTU = 3'd4;
   localparam logic [2:0] M_GEU = 3'd5;

   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   logic [1:0]       state_q,   state_d;
   logic [WIDTH-1:0] a_q,       a_d;
   logic [WIDTH-1:0] b_q,       b_d;
   logic [2:0]       mode_q,    mode_d;
   logic [CW-1:0]    cnt_q,     cnt_d;
   logic             decided_q, decided_d;
   logic             lt_int_q,  lt_int_d;
   logic             result_q,  result_d;
   logic             zero_q,    zero_d;
   logic             lt_q,      lt_d;

   logic [DIGIT-1:0] dig_a, dig_b;
   logic             dig_diff;
   logic             decided_now;
   logic             lt_now;
   logic             last_digit;
   logic             finish;
   logic             signed_mode;
   logic             zero_fin;
   logic             lt_fin;

   assign dig_a       = a_q[WIDTH-1 -: DIGIT];
   assign dig_b       = b_q[WIDTH-1 -: DIGIT];
   assign dig_diff    = (dig_a != dig_b);
   // Once a digit has differed, the ordering is fixed; later digits are ignored.
   assign decided_now = decided_q | dig_diff;
   assign lt_now      = decided_q ? lt_int_q : (dig_a < dig_b);
   assign last_digit  = (cnt_q == CNT_LAST);
   assign zero_fin    = ~decided_now;
   assign lt_fin      = decided_now & lt_now;
   assign signed_mode = (bus_if.mode == M_LT) || (bus_if.mode == M_GE);

`ifdef BRANCH_CMP_EARLY_EXIT_EN
   assign finish = last_digit | dig_diff;
`else
   assign finish = last_digit;
`endif

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      mode_d    = mode_q;
      cnt_d     = cnt_q;
      decided_d = decided_q;
      lt_int_d  = lt_int_q;
      result_d  = result_q;
      zero_d    = zero_q;
      lt_d      = lt_q;
      case (state_q)
         ST_IDLE: begin
            // flush has priority over a simultaneous start
            if (bus_if.start && !bus_if.flush) begin
               a_d    = bus_if.ID_rd1;
               b_d    = bus_if.ID_rd2;
               mode_d = bus_if.mode;
               // Flipping the sign bits turns two's-complement order into
               // plain unsigned order, so one digit comparator serves both.
               a_d[WIDTH-1] = bus_if.ID_rd1[WIDTH-1] ^ signed_mode;
               b_d[WIDTH-1] = bus_if.ID_rd2[WIDTH-1] ^ signed_mode;
               cnt_d     = '0;
               decided_d = 1'b0;
               lt_int_d  = 1'b0;
               state_d   = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (bus_if.flush) begin
               state_d = ST_IDLE;
            end else begin
               a_d       = a_q << DIGIT;
               b_d       = b_q << DIGIT;
               cnt_d     = cnt_q + 1'b1;
               decided_d = decided_now;
               lt_int_d  = lt_now;
               if (finish) begin
                  zero_d = zero_fin;
                  lt_d   = lt_fin;
                  case (mode_q)
                     M_NE:         result_d = ~zero_fin;
                     M_LT, M_LTU:  result_d = lt_fin;
                     M_GE, M_GEU:  result_d = ~lt_fin;
                     default:      result_d = zero_fin;   // EQ and reserved
                  endcase
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         mode_q    <= M_EQ;
         cnt_q     <= '0;
         decided_q <= 1'b0;
         lt_int_q  <= 1'b0;
         result_q  <= 1'b0;
         zero_q    <= 1'b0;
         lt_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         mode_q    <= mode_d;
         cnt_q     <= cnt_d;
         decided_q <= decided_d;
         lt_int_q  <= lt_int_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         lt_q      <= lt_d;
      end
   end

   assign bus_if.ready  = (state_q == ST_IDLE);
   assign bus_if.valid  = (state_q == ST_DONE);
   assign bus_if.result = result_q;
   assign bus_if.zero   = zero_q;
   assign bus_if.lt     = lt_q;

endmodule

// File: tb/tb_branch_cmp_serial.sv
// tb/tb_branch_cmp_serial.sv - scoreboard bench for branch_cmp_serial
module tb_branch_cmp_serial;

   localparam int WIDTH = 32;
   localparam int DIGIT = 8;
   localparam int N     = WIDTH / DIGIT;
`ifdef BRANCH_CMP_EARLY_EXIT_EN
   localparam int LAT_MSB_DIFF = 1;
`else
   localparam int LAT_MSB_DIFF = N;
`endif

   typedef struct {
      logic r;
      logic z;
      logic l;
      int   lat;
      int   acc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cycle_cnt;
   int   checks;
   int   failures;
   int   last_acc;
   logic prev_valid;
   exp_t sb_q[$];

   branch_cmp_serial_if #(.WIDTH(WIDTH)) bus();

   branch_cmp_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk_i  (clk),
      .rst_n  (rst_n),
      .bus_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cycle_cnt = 0;
   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: pops one expectation per valid pulse and checks the cycle after.
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_valid) begin
            chk("ready_after_valid", int'(bus.ready), 1);
            chk("valid_one_cycle", int'(bus.valid), 0);
         end
         if (bus.valid) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_valid", 1, 0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("result", int'(bus.result), int'(e.r));
               chk("zero", int'(bus.zero), int'(e.z));
               chk("lt", int'(bus.lt), int'(e.l));
               chk("latency", cycle_cnt - e.acc, e.lat);
            end
         end
         prev_valid = bus.valid;
      end else begin
         prev_valid = 1'b0;
      end
   end

   task automatic issue(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b,
                        input logic er, input logic ez, input logic el,
                        input int elat, input bit push);
      int guard;
      exp_t e;
      guard = 0;
      @(negedge clk);
      while (!bus.ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.ready) chk("issue_wait_ready", 0, 1);
      bus.start  = 1'b1;
      bus.mode   = m;
      bus.ID_rd1 = a;
      bus.ID_rd2 = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      last_acc  = cycle_cnt;
      if (push) begin
         e.r = er; e.z = ez; e.l = el; e.lat = elat; e.acc = cycle_cnt;
         sb_q.push_back(e);
      end
   endtask

   initial begin
      int prev;
      int guard;
      checks     = 0;
      failures   = 0;
      prev_valid = 1'b0;
      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.mode   = 3'd0;
      bus.ID_rd1 = '0;
      bus.ID_rd2 = '0;
      bus.flush  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", int'(bus.ready), 1);
      chk("rst_valid", int'(bus.valid), 0);
      chk("rst_result", int'(bus.result), 0);
      chk("rst_zero", int'(bus.zero), 0);
      chk("rst_lt", int'(bus.lt), 0);
      rst_n = 1'b1;

      // 1. EQ equal zeros
      issue(3'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, N, 1'b1);
      // 2. LTU 1 vs 0, difference in last digit; start pulsed while busy is ignored
      issue(3'd4, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, N, 1'b1);
      @(negedge clk);
      bus.start = 1'b1; bus.mode = 3'd0; bus.ID_rd1 = '0; bus.ID_rd2 = '0;
      @(posedge clk);
      #1 bus.start = 1'b0;
      // 3. signed -1 < 2, unsigned 0xFFFFFFFF > 2
      issue(3'd2, 32'hFFFF_FFFF, 32'h2, 1'b1, 1'b0, 1'b1, LAT_MSB_DIFF, 1'b1);
      issue(3'd4, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0, 1'b0, LAT_MSB_DIFF, 1'b1);
      // reserved modes behave as EQ
      issue(3'd6, 32'h1, 32'h2, 1'b0, 1'b0, 1'b1, N, 1'b1);
      issue(3'd7, 32'hA5A5_0001, 32'hA5A5_0001, 1'b1, 1'b1, 1'b0, N, 1'b1);
      // 4. GE then NE back-to-back
      issue(3'd3, 32'h4, 32'h4, 1'b1, 1'b1, 1'b0, N, 1'b1);
      prev = last_acc;
      issue(3'd1, 32'h4, 32'h4, 1'b0, 1'b1, 1'b0, N, 1'b1);
      chk("b2b_spacing", last_acc - prev, N + 2);

      // 5. flush on the 2nd BUSY edge
      issue(3'd0, 32'h5, 32'h5, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.flush = 1'b0;
      chk("flush_ready", int'(bus.ready), 1);
      chk("flush_valid", int'(bus.valid), 0);
      chk("flush_result_held", int'(bus.result), 0);
      chk("flush_zero_held", int'(bus.zero), 1);
      chk("flush_lt_held", int'(bus.lt), 0);
      repeat (6) @(negedge clk);
      // flush and start together in IDLE: start is refused
      bus.flush = 1'b1; bus.start = 1'b1; bus.mode = 3'd0;
      @(posedge clk);
      #1;
      bus.flush = 1'b0; bus.start = 1'b0;
      chk("flush_beats_start", int'(bus.ready), 1);
      repeat (6) @(negedge clk);
      issue(3'd5, 32'h0, 32'h7, 1'b0, 1'b0, 1'b1, N, 1'b1);

      // 6. asynchronous reset mid-BUSY
      issue(3'd0, 32'h3, 32'h3, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_ready", int'(bus.ready), 1);
      chk("arst_valid", int'(bus.valid), 0);
      chk("arst_result", int'(bus.result), 0);
      chk("arst_zero", int'(bus.zero), 0);
      chk("arst_lt", int'(bus.lt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(3'd0, 32'h9, 32'h9, 1'b1, 1'b1, 1'b0, N, 1'b1);

      guard = 0;
      while (sb_q.size() != 0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
